// File: rtl/dem_xuong_tff.sv
// Loadable down-counter built from T-type bit registers, with one-shot/auto-reload modes,
// cascadable borrow-out and a sticky done flag. Define DEM_XUONG_HEX_EN to add a hex0 decoder.
module dem_xuong_tff #(
  parameter int unsigned W = 4
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         en,
  input  logic         bin,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         auto,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
`ifdef DEM_XUONG_HEX_EN
  ,
  output logic [6:0]   hex0
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e       state_q;
  logic [W-1:0] r_q;

  logic         step;
  logic         q_zero;
  logic         low_zero;
  logic [W-1:0] tog;
  logic [W-1:0] q_dec;

  // Bit i toggles when every lower bit is already 0; the q_zero gate stops 0 -> all-ones.
  always_comb begin
    step     = en & bin;
    q_zero   = (q == '0);
    tog      = '0;
    low_zero = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      tog[i]   = step & ~q_zero & low_zero;
      low_zero = low_zero & ~q[i];
    end
    q_dec = q ^ tog;
  end

  // Borrow-out for the next stage: only the terminal step of a running count, and a load wins.
  assign tc = (state_q == StRun) & step & q_zero & ~ld;

  always_ff @(posedge ck) begin
    if (rs) begin
      state_q <= StIdle;
      q       <= '0;
      r_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ld) begin
            q       <= d;
            r_q     <= d;
            state_q <= StRun;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        StRun: begin
          if (ld) begin
            q   <= d;
            r_q <= d;
          end else if (step) begin
            if (!q_zero) begin
              q <= q_dec;
            end else if (auto) begin
              q <= r_q;
            end else begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          if (ld) begin
            q       <= d;
            r_q     <= d;
            state_q <= StRun;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEM_XUONG_HEX_EN
  logic [3:0] nib;

  // Narrow counters show their value in the low nibble with zeros above.
  if (W >= 4) begin : g_nib_full
    assign nib = q[3:0];
  end else begin : g_nib_pad
    assign nib = {{(4 - W){1'b0}}, q};
  end

  // Active-low segments, bit order g..a.
  always_comb begin
    hex0 = 7'b1111111;
    case (nib)
      4'h0: hex0 = 7'b1000000;
      4'h1: hex0 = 7'b1111001;
      4'h2: hex0 = 7'b0100100;
      4'h3: hex0 = 7'b0110000;
      4'h4: hex0 = 7'b0011001;
      4'h5: hex0 = 7'b0010010;
      4'h6: hex0 = 7'b0000010;
      4'h7: hex0 = 7'b1111000;
      4'h8: hex0 = 7'b0000000;
      4'h9: hex0 = 7'b0010000;
      4'hA: hex0 = 7'b0001000;
      4'hB: hex0 = 7'b0000011;
      4'hC: hex0 = 7'b1000110;
      4'hD: hex0 = 7'b0100001;
      4'hE: hex0 = 7'b0000110;
      4'hF: hex0 = 7'b0001110;
      default: hex0 = 7'b1111111;
    endcase
  end
`endif

endmodule

// File: tb/tb_dem_xuong_tff.sv
// Bench for dem_xuong_tff: arithmetic reference model checked every cycle plus literal pins.
module tb_dem_xuong_tff;

  localparam int W = 4;

  logic         ck;
  logic         rs;
  logic         en;
  logic         bin;
  logic         ld;
  logic [W-1:0] d;
  logic         auto;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;
`ifdef DEM_XUONG_HEX_EN
  logic [6:0]   hex0;
`endif

  dem_xuong_tff #(.W(W)) dut (
    .ck   (ck),
    .rs   (rs),
    .en   (en),
    .bin  (bin),
    .ld   (ld),
    .d    (d),
    .auto (auto),
    .q    (q),
    .tc   (tc),
    .busy (busy),
    .done (done)
`ifdef DEM_XUONG_HEX_EN
    ,
    .hex0 (hex0)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_vec  = 0;
  int n_bad  = 0;
  int tc_seen = 0;

  // Model: mode 0 idle, 1 running, 2 finished; counts kept as plain integers.
  int m_mode  = 0;
  int m_q     = 0;
  int m_r     = 0;
  bit m_valid = 1'b0;

  logic [6:0] seg_tab [16];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge ck) begin
    if (rs) begin
      m_mode  = 0;
      m_q     = 0;
      m_r     = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (ld) begin
        m_q    = int'(d);
        m_r    = int'(d);
        m_mode = 1;
      end else if (m_mode == 1 && en && bin) begin
        if (m_q > 0) m_q = m_q - 1;
        else if (auto) m_q = m_r;
        else m_mode = 2;
      end
    end
  end

  always @(negedge ck) begin
    if (m_valid) begin
      check("q", int'(q), m_q);
      check("tc", int'(tc), int'(m_mode == 1 && en && bin && m_q == 0 && !ld));
      check("busy", int'(busy), int'(m_mode == 1));
      check("done", int'(done), int'(m_mode == 2));
`ifdef DEM_XUONG_HEX_EN
      check("hex0", int'(hex0), int'(seg_tab[m_q % 16]));
`endif
      if (tc) tc_seen++;
    end
  end

  // Applies one set of inputs across one rising edge, returning 1 time unit after it.
  task automatic drive(input logic rs_v, input logic en_v, input logic bin_v,
                       input logic ld_v, input logic [W-1:0] d_v, input logic auto_v);
    rs   = rs_v;
    en   = en_v;
    bin  = bin_v;
    ld   = ld_v;
    d    = d_v;
    auto = auto_v;
    @(posedge ck);
    #1;
  endtask

  int tc_mark;

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    rs = 1'b1; en = 1'b0; bin = 1'b0; ld = 1'b0; d = '0; auto = 1'b0;
    drive(1, 0, 0, 0, 4'd0, 0);
    drive(1, 1, 1, 1, 4'd7, 0);
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Steps in IDLE are ignored.
    repeat (5) drive(0, 1, 1, 0, 4'd0, 0);
    check("idle_q", int'(q), 0);
    check("idle_tc_count", tc_seen, 0);

    // One-shot from 5.
    drive(0, 0, 1, 1, 4'd5, 0);
    check("os_load_q", int'(q), 5);
    check("os_load_busy", int'(busy), 1);
    repeat (5) drive(0, 1, 1, 0, 4'd0, 0);
    check("os_zero_q", int'(q), 0);
    check("os_zero_busy", int'(busy), 1);
    tc_mark = tc_seen;
    drive(0, 1, 1, 0, 4'd0, 0);
    check("os_tc_pulse", tc_seen - tc_mark, 1);
    check("os_done", int'(done), 1);
    check("os_busy_off", int'(busy), 0);
    repeat (3) drive(0, 1, 1, 0, 4'd0, 0);
    check("os_hold_q", int'(q), 0);
    check("os_hold_done", int'(done), 1);

    // Auto-reload from 3: period of 4 steps.
    drive(0, 0, 1, 1, 4'd3, 1);
    tc_mark = tc_seen;
    repeat (12) drive(0, 1, 1, 0, 4'd0, 1);
    check("ar_tc_count", tc_seen - tc_mark, 3);
    check("ar_q", int'(q), 3);
    check("ar_done", int'(done), 0);

    // Cascade input toggling: only bin=1 cycles count.
    drive(0, 0, 1, 1, 4'd15, 0);
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, (i % 2 == 0), 0, 4'd0, 0);
      if (i == 27) check("bin_q28", int'(q), 1);
    end
    check("bin_q30", int'(q), 0);
    check("bin_busy", int'(busy), 1);

    // Load beats a simultaneous step.
    drive(0, 0, 1, 1, 4'd2, 0);
    drive(0, 1, 1, 1, 4'd9, 0);
    check("ld_prio_q", int'(q), 9);

    // Reset mid-run beats load.
    drive(0, 0, 1, 1, 4'd8, 0);
    repeat (2) drive(0, 1, 1, 0, 4'd0, 0);
    check("rsrun_pre_q", int'(q), 6);
    drive(1, 1, 1, 1, 4'd3, 0);
    check("rsrun_q", int'(q), 0);
    check("rsrun_busy", int'(busy), 0);
    check("rsrun_done", int'(done), 0);

    // Load of zero: next step is terminal.
    drive(0, 0, 1, 1, 4'd0, 1);
    tc_mark = tc_seen;
    drive(0, 1, 1, 0, 4'd0, 1);
    check("z_tc_pulse", tc_seen - tc_mark, 1);
    check("z_busy", int'(busy), 1);

`ifdef DEM_XUONG_HEX_EN
    drive(0, 0, 1, 1, 4'hA, 0);
    check("hex_a", int'(hex0), int'(7'b0001000));
`endif

    drive(0, 0, 0, 0, 4'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
